botones_entrada: RTL and testbench

Input conditioner that sits directly upstream of the tic-tac-toe top level. It takes the two raw, bouncing, active-low board pushbuttons and produces the clean single-cycle `mover` and `colocar` strobes the game logic consumes. Each channel has a two-flop synchronizer, a debounce filter and a press-edge detector. The `mover` channel also has hold-to-repeat, so the cursor can sweep the board while the button is held.

---
 rtl/botones_entrada.sv | 117 +++++++++++
 tb/tb_botones_entrada.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/botones_entrada.sv
// Input conditioner for the two active-low board pushbuttons: synchronize, debounce,
// detect presses and, on the mover channel, generate hold-to-repeat strobes.
module botones_entrada #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mover_n,
    input  logic       btn_colocar_n,
    output logic       mover,
    output logic       colocar,
    output logic [1:0] estado
);

    localparam int DB_W    = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX < 1) ? 1 : $clog2(RPT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RPT  = 2'd2
    } state_t;

    // Channel index 1 = mover, 0 = colocar; all levels active-low until estado.
    logic [1:0]      raw;
    logic [1:0]      sync_p0;
    logic [1:0]      sync_p1;
    logic [1:0]      stable;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      differ;
    logic [1:0]      flip;
    logic [1:0]      press_flip;
    logic [1:0]      release_flip;

    state_t          state;
    logic [RPT_W-1:0] rpt_cnt;

    assign raw          = {btn_mover_n, btn_colocar_n};
    assign differ       = sync_p1 ^ stable;
    assign press_flip   = flip & stable;
    assign release_flip = flip & ~stable;
    assign estado       = ~stable;

    // Flip only after the new level has been seen for the full filter window.
    always_comb begin
        flip = '0;
        for (int i = 0; i < 2; i++) begin
            flip[i] = differ[i] && (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES));
        end
    end

    // Synchronizer and debounce stages
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 2'b11;
            sync_p1 <= 2'b11;
            stable  <= 2'b11;
            colocar <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            colocar <= press_flip[0];
            for (int i = 0; i < 2; i++) begin
                if (!differ[i]) begin
                    db_cnt[i] <= '0;
                end else if (flip[i]) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Repeat FSM: expiry is detected at count 1 so pulses land exactly N cycles apart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rpt_cnt <= '0;
            mover   <= 1'b0;
        end else begin
            mover <= press_flip[1];
            case (state)
                IDLE: begin
                    if (press_flip[1] && (REPEAT_DELAY > 0)) begin
                        state   <= WAIT;
                        rpt_cnt <= RPT_W'(REPEAT_DELAY);
                    end
                end
                WAIT, RPT: begin
                    if (release_flip[1]) begin
                        state   <= IDLE;
                        rpt_cnt <= '0;
                    end else if (rpt_cnt <= RPT_W'(1)) begin
                        mover   <= 1'b1;
                        state   <= RPT;
                        rpt_cnt <= RPT_W'(REPEAT_PERIOD);
                    end else begin
                        rpt_cnt <= rpt_cnt - RPT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    rpt_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_botones_entrada.sv
// Scoreboard bench for botones_entrada: expected strobes are queued by cycle number
// and matched by monitors whenever a strobe appears.
module tb_botones_entrada;

    localparam int D   = 4;
    localparam int R   = 10;
    localparam int P   = 3;
    localparam int LAT = D + 3;   // stimulus negedge -> first negedge showing the strobe

    typedef struct {
        int         cyc;
        logic [1:0] which;        // bit1 = mover, bit0 = colocar
    } ev_t;

    logic       clk;
    logic       rst;
    logic       btn_m;
    logic       btn_c;
    logic       btn_m0;
    logic       mover;
    logic       colocar;
    logic [1:0] estado;
    logic       mover0;
    logic       colocar0;
    logic [1:0] estado0;

    int  cyc;
    int  pass_cnt;
    int  total_cnt;
    ev_t sbq[$];
    ev_t q0[$];

    botones_entrada #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(R), .REPEAT_PERIOD(P)) dut (
        .clk(clk), .rst(rst), .btn_mover_n(btn_m), .btn_colocar_n(btn_c),
        .mover(mover), .colocar(colocar), .estado(estado)
    );

    botones_entrada #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(P)) dut_nr (
        .clk(clk), .rst(rst), .btn_mover_n(btn_m0), .btn_colocar_n(1'b1),
        .mover(mover0), .colocar(colocar0), .estado(estado0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void expect_ev(input int t, input logic [1:0] w);
        ev_t ev;
        ev.cyc   = t;
        ev.which = w;
        for (int i = 0; i < sbq.size(); i++) begin
            if (sbq[i].cyc == t) begin
                sbq[i].which = sbq[i].which | w;
                return;
            end
            if (sbq[i].cyc > t) begin
                sbq.insert(i, ev);
                return;
            end
        end
        sbq.push_back(ev);
    endfunction

    // Repeat pulses strictly before the release flip survive.
    function automatic void expect_repeats(input int first, input int rflip);
        for (int p = first + R; p < rflip; p += P) expect_ev(p, 2'b10);
    endfunction

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    always @(negedge clk) begin : mon
        ev_t e;
        if (mover || colocar) begin
            if (sbq.size() == 0) begin
                check("unexpected_strobe", cyc, -1);
            end else begin
                e = sbq.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("strobe_which", int'({mover, colocar}), int'(e.which));
            end
        end
    end

    always @(negedge clk) begin : mon0
        ev_t e;
        if (colocar0) check("nr_colocar", 1, 0);
        if (mover0) begin
            if (q0.size() == 0) begin
                check("nr_unexpected", cyc, -1);
            end else begin
                e = q0.pop_front();
                check("nr_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  c;
        ev_t e0;
        cyc       = 0;
        pass_cnt  = 0;
        total_cnt = 0;
        btn_m     = 1'b1;
        btn_c     = 1'b1;
        btn_m0    = 1'b1;
        rst       = 1'b1;
        #2 rst    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mover", int'(mover), 0);
        check("rst_colocar", int'(colocar), 0);
        check("rst_estado", int'(estado), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 1: clean colocar press
        c = cyc;
        btn_c = 1'b0;
        expect_ev(c + LAT, 2'b01);
        wait_until(c + LAT - 1);
        check("s1_estado_before", int'(estado), 0);
        wait_until(c + LAT);
        check("s1_estado_rise", int'(estado), 1);
        wait_until(c + 40);
        c = cyc;
        btn_c = 1'b1;
        wait_until(c + LAT - 1);
        check("s1_estado_held", int'(estado), 1);
        wait_until(c + LAT);
        check("s1_estado_fall", int'(estado), 0);
        wait_until(c + 20);
        check("s1_pending", sbq.size(), 0);

        // 2: bouncing mover, release lands on the first repeat slot
        for (int k = 0; k < 10; k++) begin
            btn_m = k[0];
            repeat (2) @(negedge clk);
        end
        check("s2_estado_bounce", int'(estado), 0);
        c = cyc;
        btn_m = 1'b0;
        expect_ev(c + LAT, 2'b10);
        expect_repeats(c + LAT, c + 10 + LAT);
        wait_until(c + 10);
        btn_m = 1'b1;
        wait_until(c + 40);
        check("s2_pending", sbq.size(), 0);

        // 3: held mover, repeat cadence
        c = cyc;
        btn_m = 1'b0;
        expect_ev(c + LAT, 2'b10);
        expect_repeats(c + LAT, c + 40 + LAT);
        wait_until(c + 40);
        btn_m = 1'b1;
        wait_until(c + 70);
        check("s3_pending", sbq.size(), 0);

        // 4: simultaneous presses, then colocar re-pressed during repeat
        c = cyc;
        btn_m = 1'b0;
        btn_c = 1'b0;
        expect_ev(c + LAT, 2'b11);
        expect_repeats(c + LAT, c + 40 + LAT);
        wait_until(c + LAT + 1);
        check("s4_estado_both", int'(estado), 3);
        wait_until(c + 12);
        btn_c = 1'b1;
        wait_until(c + 22);
        btn_c = 1'b0;
        expect_ev(c + 22 + LAT, 2'b01);
        wait_until(c + 40);
        btn_m = 1'b1;
        btn_c = 1'b1;
        wait_until(c + 70);
        check("s4_pending", sbq.size(), 0);

        // 5a: reset during a colocar debounce, button kept held
        c = cyc;
        btn_c = 1'b0;
        wait_until(c + 3);
        rst = 1'b0;
        #1;
        check("s5_colocar_rst", int'(colocar), 0);
        check("s5_estado_rst", int'(estado), 0);
        wait_until(c + 5);
        rst = 1'b1;
        expect_ev(c + 5 + LAT, 2'b01);
        wait_until(c + 20);
        btn_c = 1'b1;
        wait_until(c + 40);
        check("s5a_pending", sbq.size(), 0);

        // 5b: reset mid-WAIT, button kept held
        c = cyc;
        btn_m = 1'b0;
        expect_ev(c + LAT, 2'b10);
        wait_until(c + 12);
        check("s5_estado_pre", int'(estado), 2);
        rst = 1'b0;
        #1;
        check("s5_mover_rst", int'(mover), 0);
        check("s5_estado_wait_rst", int'(estado), 0);
        wait_until(c + 15);
        rst = 1'b1;
        expect_ev(c + 15 + LAT, 2'b10);
        expect_repeats(c + 15 + LAT, c + 30 + LAT);
        wait_until(c + 30);
        btn_m = 1'b1;
        wait_until(c + 55);
        check("s5b_pending", sbq.size(), 0);

        // 6: repeat disabled
        c = cyc;
        btn_m0 = 1'b0;
        e0.cyc   = c + LAT;
        e0.which = 2'b10;
        q0.push_back(e0);
        wait_until(c + LAT + 1);
        check("s6_estado", int'(estado0), 2);
        wait_until(c + 40);
        btn_m0 = 1'b1;
        wait_until(c + 60);
        check("s6_pending", q0.size(), 0);
        check("s6_main_pending", sbq.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
